// File: rtl/opnd_fetch_pkg.sv
// opnd_fetch_pkg: operand kinds, widths, GPR encodings and operand-extraction helpers for opnd_fetch
package opnd_fetch_pkg;
  localparam int OPND_SRC_REG = 0;
  localparam int OPND_SRC_IMM = 1;
  localparam logic [1:0] KIND_ZERO = 2'b00;
  localparam logic [1:0] KIND_REG = 2'(1 << OPND_SRC_REG);
  localparam logic [1:0] KIND_IMM = 2'(1 << OPND_SRC_IMM);
  localparam logic [1:0] KIND_ERR = 2'b11;
  localparam logic [1:0] OPND_W8 = 2'b00;
  localparam logic [1:0] OPND_W16 = 2'b01;
  localparam logic [1:0] OPND_W32 = 2'b10;
  localparam logic [2:0] REG_EAX = 3'd0;
  localparam logic [2:0] REG_ECX = 3'd1;
  localparam logic [2:0] REG_EDX = 3'd2;
  localparam logic [2:0] REG_EBX = 3'd3;
  localparam logic [2:0] REG_ESP = 3'd4;
  localparam logic [2:0] REG_EBP = 3'd5;
  localparam logic [2:0] REG_ESI = 3'd6;
  localparam logic [2:0] REG_EDI = 3'd7;

  typedef logic [7:0][31:0] gpr_t;

  typedef struct packed {
    logic        err;
    logic [31:0] opnd1;
    logic [31:0] opnd0;
  } rsp_t;

  // 8-bit selects 4-7 name the high byte (AH..BH) of the register selected by sel[1:0]
  function automatic logic [31:0] subreg_extract(logic [31:0] reg32, logic [2:0] sel, logic [1:0] width);
    return width == OPND_W8 ? {24'h0, sel[2] ? reg32[15:8] : reg32[7:0]}
         : width == OPND_W16 ? {16'h0, reg32[15:0]} : reg32;
  endfunction

  function automatic logic [31:0] opnd_pick(logic [1:0] kind, logic [2:0] sel, logic [1:0] width,
                                            logic [31:0] imm, gpr_t gprs);
    logic [2:0] idx;
    idx = width == OPND_W8 ? {1'b0, sel[1:0]} : sel;
    return kind == KIND_REG ? subreg_extract(gprs[idx], sel, width)
         : kind == KIND_IMM ? subreg_extract(imm, sel, width) : 32'h0;
  endfunction
endpackage

// File: rtl/opnd_fetch_if.sv
// opnd_fetch_if: decode-side request and ALU-side response handshakes of the operand fetch unit
interface opnd_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  src0_kind;
  logic [1:0]  src1_kind;
  logic [2:0]  src0_sel;
  logic [2:0]  src1_sel;
  logic [1:0]  src_width;
  logic [31:0] imm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] opnd0_r;
  logic [31:0] opnd1_r;
  logic        rsp_err;

  modport master (
    output req_valid, src0_kind, src1_kind, src0_sel, src1_sel, src_width, imm, rsp_ready,
    input  req_ready, rsp_valid, opnd0_r, opnd1_r, rsp_err
  );

  modport slave (
    input  req_valid, src0_kind, src1_kind, src0_sel, src1_sel, src_width, imm, rsp_ready,
    output req_ready, rsp_valid, opnd0_r, opnd1_r, rsp_err
  );
endinterface

// File: rtl/opnd_fetch_sync_fifo.sv
// opnd_fetch_sync_fifo: count-based synchronous FIFO, DEPTH a power of 2
module opnd_fetch_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/opnd_fetch.sv
// opnd_fetch: shadow-GPR source-operand fetch with a DEPTH-entry response queue.
// Define OPND_FETCH_BYPASS_EN to let a request see the snap_load/wb_en data written in the same cycle.
module opnd_fetch
  import opnd_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snap_load,
  input  logic [31:0] i_eax, i_ebx, i_ecx, i_edx, i_esi, i_edi, i_esp, i_ebp,
  input  logic        wb_en,
  input  logic [31:0] w_eax, w_ebx, w_ecx, w_edx, w_esi, w_edi, w_esp, w_ebp,
  opnd_fetch_if.slave bus
);
  gpr_t gpr_q, gpr_d, rd_gpr;
  rsp_t din, head, last_q;
  logic push, pop, full, empty;

  always_comb begin
    gpr_d = snap_load ? {i_edi, i_esi, i_ebp, i_esp, i_ebx, i_edx, i_ecx, i_eax}
          : wb_en ? {w_edi, w_esi, w_ebp, w_esp, w_ebx, w_edx, w_ecx, w_eax} : gpr_q;
  end

`ifdef OPND_FETCH_BYPASS_EN
  assign rd_gpr = gpr_d;
`else
  assign rd_gpr = gpr_q;
`endif

  assign din = '{err:   bus.src0_kind == KIND_ERR || bus.src1_kind == KIND_ERR,
                 opnd1: opnd_pick(bus.src1_kind, bus.src1_sel, bus.src_width, bus.imm, rd_gpr),
                 opnd0: opnd_pick(bus.src0_kind, bus.src0_sel, bus.src_width, bus.imm, rd_gpr)};

  assign push = bus.req_valid && bus.req_ready;
  assign pop = bus.rsp_valid && bus.rsp_ready;
  assign bus.req_ready = !full;
  assign bus.rsp_valid = !empty;
  // once drained, the outputs keep showing the last entry handed to the ALU
  assign {bus.rsp_err, bus.opnd1_r, bus.opnd0_r} = empty ? last_q : head;

  always_ff @(posedge clk) begin
    gpr_q <= rst ? '0 : gpr_d;
    last_q <= rst ? '0 : pop ? head : last_q;
  end

  opnd_fetch_sync_fifo #(.DEPTH(DEPTH), .W($bits(rsp_t))) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (din),
    .dout (head),
    .full (full),
    .empty(empty)
  );
endmodule

// File: tb/tb_opnd_fetch.sv
// tb_opnd_fetch: directed bench with a response scoreboard for opnd_fetch (DEPTH=2)
module tb_opnd_fetch;
  import opnd_fetch_pkg::*;

  logic clk, rst, snap_load, wb_en;
  logic [31:0] i_eax, i_ebx, i_ecx, i_edx, i_esi, i_edi, i_esp, i_ebp;
  logic [31:0] w_eax, w_ebx, w_ecx, w_edx, w_esi, w_edi, w_esp, w_ebp;
  int total, passed, pops;
  logic [31:0] m_gpr [8];
  rsp_t sb [$];

  opnd_fetch_if bus ();

  opnd_fetch #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .snap_load(snap_load),
    .i_eax(i_eax), .i_ebx(i_ebx), .i_ecx(i_ecx), .i_edx(i_edx),
    .i_esi(i_esi), .i_edi(i_edi), .i_esp(i_esp), .i_ebp(i_ebp),
    .wb_en(wb_en),
    .w_eax(w_eax), .w_ebx(w_ebx), .w_ecx(w_ecx), .w_edx(w_edx),
    .w_esi(w_esi), .w_edi(w_edi), .w_esp(w_esp), .w_ebp(w_ebp),
    .bus(bus)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_opnd(logic [1:0] kind, logic [2:0] sel, logic [1:0] w, logic [31:0] imm);
    logic [31:0] base;
    if (kind == 2'b01) base = (w == 2'b00) ? m_gpr[sel[1:0]] : m_gpr[sel];
    else if (kind == 2'b10) base = imm;
    else return 32'h0;
    case (w)
      2'b00: return sel >= 3'd4 ? {24'h0, base[15:8]} : {24'h0, base[7:0]};
      2'b01: return base & 32'h0000FFFF;
      default: return base;
    endcase
  endfunction

  task automatic model_update();
    if (snap_load) m_gpr = '{i_eax, i_ecx, i_edx, i_ebx, i_esp, i_ebp, i_esi, i_edi};
    else if (wb_en) m_gpr = '{w_eax, w_ecx, w_edx, w_ebx, w_esp, w_ebp, w_esi, w_edi};
  endtask

  task automatic push_exp();
    rsp_t e;
    e.opnd0 = model_opnd(bus.src0_kind, bus.src0_sel, bus.src_width, bus.imm);
    e.opnd1 = model_opnd(bus.src1_kind, bus.src1_sel, bus.src_width, bus.imm);
    e.err = bus.src0_kind == 2'b11 || bus.src1_kind == 2'b11;
    sb.push_back(e);
  endtask

  // called at the negedge with inputs settled; advances exactly one clock
  task automatic tick();
    rsp_t e;
    if (rst) begin
      sb.delete();
      foreach (m_gpr[i]) m_gpr[i] = 32'h0;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) chk("unexpected_rsp", {31'h0, bus.rsp_valid}, 32'h0);
        else begin
          e = sb.pop_front();
          chk("sb_opnd0", bus.opnd0_r, e.opnd0);
          chk("sb_opnd1", bus.opnd1_r, e.opnd1);
          chk("sb_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
          pops++;
        end
      end
`ifdef OPND_FETCH_BYPASS_EN
      model_update();
      if (bus.req_valid && bus.req_ready) push_exp();
`else
      if (bus.req_valid && bus.req_ready) push_exp();
      model_update();
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(logic v, logic [1:0] k0, logic [2:0] s0, logic [1:0] k1, logic [2:0] s1,
                         logic [1:0] w, logic [31:0] im);
    bus.req_valid = v;
    bus.src0_kind = k0;
    bus.src0_sel = s0;
    bus.src1_kind = k1;
    bus.src1_sel = s1;
    bus.src_width = w;
    bus.imm = im;
  endtask

  initial begin
    int p0;
    total = 0; passed = 0; pops = 0;
    foreach (m_gpr[i]) m_gpr[i] = 32'h0;
    rst = 1; snap_load = 0; wb_en = 0;
    {i_eax, i_ebx, i_ecx, i_edx, i_esi, i_edi, i_esp, i_ebp} = '0;
    {w_eax, w_ebx, w_ecx, w_edx, w_esi, w_edi, w_esp, w_ebp} = '0;
    set_req(0, 2'b00, 3'd0, 2'b00, 3'd0, OPND_W32, 32'h0);
    bus.rsp_ready = 0;
    @(negedge clk);
    tick(); tick();
    rst = 0;
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_opnd0", bus.opnd0_r, 32'h0);
    chk("rst_opnd1", bus.opnd1_r, 32'h0);
    chk("rst_err", {31'h0, bus.rsp_err}, 32'h0);

    // snapshot load, then AL / AH
    snap_load = 1;
    i_eax = 32'h11223344; i_ebx = 32'hB0B1B2B3; i_ecx = 32'h7; i_edx = 32'hD0D1D2D3;
    i_esi = 32'h5151A5A5; i_edi = 32'hD1D1D1D1; i_esp = 32'h0000FFF0; i_ebp = 32'hBEBE0000;
    tick();
    snap_load = 0;
    set_req(1, 2'b01, REG_EAX, 2'b01, 3'd4, OPND_W8, 32'h0);
    chk("lat_no_early_valid", {31'h0, bus.rsp_valid}, 32'h0);
    tick();
    set_req(0, 2'b00, 3'd0, 2'b00, 3'd0, OPND_W32, 32'h0);
    chk("al_ah_valid", {31'h0, bus.rsp_valid}, 32'h1);
    chk("al_opnd0", bus.opnd0_r, 32'h44);
    chk("ah_opnd1", bus.opnd1_r, 32'h33);
    bus.rsp_ready = 1;
    tick();
    chk("empty_hold_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("empty_hold_opnd0", bus.opnd0_r, 32'h44);

    // immediate W16 / zero kind / error kind / imm W8 high byte / width 11 as W32
    set_req(1, 2'b10, 3'd0, 2'b00, 3'd0, OPND_W16, 32'hDEADBEEF);
    tick();
    set_req(1, 2'b10, 3'd0, 2'b11, REG_EBX, OPND_W32, 32'h12345678);
    chk("imm16_opnd0", bus.opnd0_r, 32'h0000BEEF);
    chk("zero_opnd1", bus.opnd1_r, 32'h0);
    chk("imm16_err", {31'h0, bus.rsp_err}, 32'h0);
    tick();
    set_req(1, 2'b10, 3'd5, 2'b01, REG_EDX, OPND_W8, 32'hDEADBEEF);
    chk("err_flag", {31'h0, bus.rsp_err}, 32'h1);
    chk("err_opnd1", bus.opnd1_r, 32'h0);
    tick();
    set_req(1, 2'b01, REG_ESI, 2'b01, REG_EBP, 2'b11, 32'h0);
    chk("imm8_hi_opnd0", bus.opnd0_r, 32'hBE);
    chk("dl_opnd1", bus.opnd1_r, 32'hD3);
    tick();
    set_req(0, 2'b00, 3'd0, 2'b00, 3'd0, OPND_W32, 32'h0);
    chk("w11_opnd0", bus.opnd0_r, 32'h5151A5A5);
    chk("w11_opnd1", bus.opnd1_r, 32'hBEBE0000);
    tick();

    // backpressure: three requests into a two-entry queue
    bus.rsp_ready = 0;
    set_req(1, 2'b10, 3'd0, 2'b00, 3'd0, OPND_W32, 32'hA0000001);
    chk("bp_ready0", {31'h0, bus.req_ready}, 32'h1);
    tick();
    set_req(1, 2'b10, 3'd0, 2'b00, 3'd0, OPND_W32, 32'hA0000002);
    chk("bp_ready1", {31'h0, bus.req_ready}, 32'h1);
    tick();
    set_req(1, 2'b10, 3'd0, 2'b00, 3'd0, OPND_W32, 32'hA0000003);
    chk("bp_full", {31'h0, bus.req_ready}, 32'h0);
    tick(); tick();
    chk("bp_still_full", {31'h0, bus.req_ready}, 32'h0);
    chk("bp_head_stable", bus.opnd0_r, 32'hA0000001);
    bus.rsp_ready = 1;
    for (int i = 0; i < 12 && !(sb.size() == 0 && !bus.req_valid); i++) begin
      if (bus.req_valid && bus.req_ready) begin
        tick();
        set_req(0, 2'b00, 3'd0, 2'b00, 3'd0, OPND_W32, 32'h0);
      end else tick();
    end
    chk("bp_drained", sb.size(), 32'h0);
    chk("bp_last", bus.opnd0_r, 32'hA0000003);

    // writeback in the same cycle as a request for ECX
    wb_en = 1;
    w_eax = 32'h11223344; w_ebx = 32'hB0B1B2B3; w_ecx = 32'h5; w_edx = 32'hD0D1D2D3;
    w_esi = 32'h5151A5A5; w_edi = 32'hD1D1D1D1; w_esp = 32'h0000FFF0; w_ebp = 32'hBEBE0000;
    set_req(1, 2'b01, REG_ECX, 2'b00, 3'd0, OPND_W32, 32'h0);
    tick();
    wb_en = 0;
    set_req(1, 2'b01, REG_ECX, 2'b00, 3'd0, OPND_W32, 32'h0);
`ifdef OPND_FETCH_BYPASS_EN
    chk("wb_same_cycle", bus.opnd0_r, 32'h5);
`else
    chk("wb_same_cycle", bus.opnd0_r, 32'h7);
`endif
    tick();
    chk("wb_after", bus.opnd0_r, 32'h5);
    // snap_load beats wb_en
    snap_load = 1; wb_en = 1;
    i_edx = 32'h5A5A0001; w_edx = 32'hEEEE0002;
    set_req(0, 2'b00, 3'd0, 2'b00, 3'd0, OPND_W32, 32'h0);
    tick();
    snap_load = 0; wb_en = 0;
    set_req(1, 2'b01, REG_EDX, 2'b00, 3'd0, OPND_W32, 32'h0);
    tick();
    set_req(0, 2'b00, 3'd0, 2'b00, 3'd0, OPND_W32, 32'h0);
    chk("snap_over_wb", bus.opnd0_r, 32'h5A5A0001);
    tick();

    // reset with two entries queued
    bus.rsp_ready = 0;
    set_req(1, 2'b01, REG_EAX, 2'b00, 3'd0, OPND_W32, 32'h0);
    tick(); tick();
    set_req(0, 2'b00, 3'd0, 2'b00, 3'd0, OPND_W32, 32'h0);
    chk("pre_rst_full", {31'h0, bus.req_ready}, 32'h0);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("mid_rst_ready", {31'h0, bus.req_ready}, 32'h1);
    bus.rsp_ready = 1;
    set_req(1, 2'b01, REG_EAX, 2'b01, REG_EDI, OPND_W32, 32'h0);
    tick();
    set_req(0, 2'b00, 3'd0, 2'b00, 3'd0, OPND_W32, 32'h0);
    chk("mid_rst_gpr_eax", bus.opnd0_r, 32'h0);
    chk("mid_rst_gpr_edi", bus.opnd1_r, 32'h0);
    tick();

    // streaming: one response per cycle, queue never above one entry
    snap_load = 1;
    i_eax = 32'h01020304; i_ecx = 32'h0A0B0C0D; i_ebx = 32'hF0E0D0C0; i_edi = 32'h89ABCDEF;
    tick();
    snap_load = 0;
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      set_req(1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
      if (i > 0) begin
        chk("stream_valid", {31'h0, bus.rsp_valid}, 32'h1);
        chk("stream_ready", {31'h0, bus.req_ready}, 32'h1);
      end
      tick();
    end
    set_req(0, 2'b00, 3'd0, 2'b00, 3'd0, OPND_W32, 32'h0);
    tick();
    chk("stream_pops", pops - p0, 32'd20);
    chk("stream_empty", {31'h0, bus.rsp_valid}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
